multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the number of consecutive MemReady-low wait cycles after which a memory access is aborted (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports OpCode  input  6 and func  input  6: instruction fields taken from the latched instruction register, valid from DECODE onward.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port MemReady  input  1  memory completes the current access in this cycle.
REQ-007 SHALL have the following 1-bit outputs: MemRead, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst, RegWrite, MemtoReg, MemErr, Illegal.
REQ-008 SHALL have outputs PCSource  output  2, ALUSrcB  output  2, ALUop  output  3 and State  output  4 (debug).

Function
REQ-009 SHALL be a Moore FSM with these State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 SHALL use these ALUop codes: add=010, sub=110, and=000, or=001.
REQ-012 In FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=010, PCSource=00; IRWrite=PCEn=MemReady; advance to DECODE only when MemReady=1.
REQ-013 In DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=010; next state by OpCode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP; any other OpCode SHALL raise Illegal=1 for that cycle and go to FETCH.
REQ-014 In MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=010; next state MEMRD if OpCode=100011, else MEMWR.
REQ-015 In MEMRD: MemRead=1, IorD=1; advance to MEMWB on MemReady.
REQ-016 In MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-017 In MEMWR: MemWrite=1, IorD=1; advance to FETCH on MemReady.
REQ-018 In EXEC: ALUSrcA=1, ALUSrcB=00; ALUop decoded from func: 100000->010, 100010->110, 100100->000, 100101->001; any other func SHALL produce ALUop=010 and Illegal=1, with next state FETCH; otherwise next state RWB.
REQ-019 In RWB: ALUSrcA=1, ALUSrcB=00, ALUop held from the EXEC decode, RegDst=1, RegWrite=1, MemtoReg=0; next state FETCH.
REQ-020 In BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=110, PCSource=01, PCEn=Zero; next state FETCH.
REQ-021 In JUMP: PCSource=10, PCEn=1; next state FETCH.
REQ-022 SHALL run an 8-bit wait counter in FETCH, MEMRD and MEMWR that increments each cycle MemReady=0 and clears on any state change.
REQ-023 When the wait counter equals MEM_TIMEOUT with MemReady=0, SHALL assert MemErr=1 for that cycle, suppress IRWrite/PCEn, and go to FETCH; MEMWB SHALL be skipped.
REQ-024 If MemReady=1 in the timeout cycle, SHALL treat the access as completed normally with no MemErr.
REQ-025 Instruction latency with zero wait: R-type 4 cycles, lw 5, sw 4, beq 3, j 3; each wait cycle adds 1.

Reset
REQ-026 While rst_n=0, SHALL immediately force State=FETCH, wait counter=0, and MemRead, MemWrite, IRWrite, PCEn, RegWrite, MemErr and Illegal to 0, regardless of clk.
REQ-027 Reset asserted mid-instruction (including mid-wait) SHALL abandon that instruction; after rst_n rises, the first edge SHALL evaluate FETCH.

Verification
REQ-028 add (OpCode 0, func 100000) with MemReady=1 -> State 0,1,6,7,0; ALUop=010 in EXEC/RWB; RegWrite=1, RegDst=1 only in RWB.
REQ-029 lw with MemReady low 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0; RegWrite=1, MemtoReg=1 exactly once.
REQ-030 beq with Zero=1, then with Zero=0 -> PCEn=1, PCSource=01 in BRANCH for the first; PCEn=0 for the second; both return to FETCH after 3 cycles.
REQ-031 OpCode 111111 -> Illegal=1 in DECODE, no RegWrite/MemWrite; func 101010 -> Illegal=1 in EXEC, RWB not entered.
REQ-032 sw with MEM_TIMEOUT=3 and MemReady held 0 -> MemErr=1 in the 4th MEMWR cycle (counter=3), then FETCH; no other MemErr pulse.
REQ-033 rst_n pulsed low during MEMWR -> MemWrite drops to 0 without a clock edge, State=0; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM with memory wait/timeout handling
// Outputs decode combinationally from the state register and are forced low while rst_n is low.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OpCode,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       MemErr,
    output logic       Illegal,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUop,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [2:0] alu_op_q, alu_op_d;

    logic       mem_read_c, mem_write_c, iord_c, ir_write_c, pc_en_c;
    logic       alu_src_a_c, reg_dst_c, reg_write_c, mem_to_reg_c;
    logic       mem_err_c, illegal_c;
    logic [1:0] pc_source_c, alu_src_b_c;
    logic [2:0] alu_op_c;
    logic       wait_state, timeout;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout    = wait_state && !MemReady && (wait_q == WAIT_LIMIT);

    always_comb begin
        state_d      = S_FETCH;
        alu_op_d     = alu_op_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        ir_write_c   = 1'b0;
        pc_en_c      = 1'b0;
        alu_src_a_c  = 1'b0;
        reg_dst_c    = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        mem_err_c    = 1'b0;
        illegal_c    = 1'b0;
        pc_source_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 3'b000;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_op_c    = ALU_ADD;
                if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (MemReady) begin
                    ir_write_c = 1'b1;
                    pc_en_c    = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_op_c    = ALU_ADD;
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = ALU_ADD;
                state_d     = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = MemReady ? S_MEMWB : S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (timeout) begin
                    mem_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = MemReady ? S_FETCH : S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                state_d     = S_RWB;
                case (func)
                    6'b100000: alu_op_c = ALU_ADD;
                    6'b100010: alu_op_c = ALU_SUB;
                    6'b100100: alu_op_c = ALU_AND;
                    6'b100101: alu_op_c = ALU_OR;
                    default: begin
                        alu_op_c  = ALU_ADD;
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
                alu_op_d = alu_op_c;
            end
            S_RWB: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = alu_op_q;
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_source_c = 2'b01;
                pc_en_c     = Zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_source_c = 2'b10;
                pc_en_c     = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Counter restarts whenever the FSM moves on or a timeout retires the access.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || timeout || !wait_state) begin
            wait_d = 8'd0;
        end else if (!MemReady) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_q   <= 8'd0;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign MemRead  = rst_n & mem_read_c;
    assign MemWrite = rst_n & mem_write_c;
    assign IorD     = rst_n & iord_c;
    assign IRWrite  = rst_n & ir_write_c;
    assign PCEn     = rst_n & pc_en_c;
    assign ALUSrcA  = rst_n & alu_src_a_c;
    assign RegDst   = rst_n & reg_dst_c;
    assign RegWrite = rst_n & reg_write_c;
    assign MemtoReg = rst_n & mem_to_reg_c;
    assign MemErr   = rst_n & mem_err_c;
    assign Illegal  = rst_n & illegal_c;
    assign PCSource = rst_n ? pc_source_c : 2'b00;
    assign ALUSrcB  = rst_n ? alu_src_b_c : 2'b00;
    assign ALUop    = rst_n ? alu_op_c : 3'b000;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_BAD  = 6'b101010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OpCode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       MemRead, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst;
    logic       RegWrite, MemtoReg, MemErr, Illegal;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUop;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_q[$];
    string       tag_q[$];

    multicycle_controller #(.MEM_TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .func(func), .Zero(Zero),
        .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCEn(PCEn), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemErr(MemErr), .Illegal(Illegal),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] pk(input logic [3:0] st, input logic mr, input logic mw,
                                       input logic iord, input logic irw, input logic pcen,
                                       input logic asa, input logic rd, input logic rw,
                                       input logic m2r, input logic merr, input logic ill,
                                       input logic [1:0] pcs, input logic [1:0] asb,
                                       input logic [2:0] aop);
        return {st, mr, mw, iord, irw, pcen, asa, rd, rw, m2r, merr, ill, pcs, asb, aop};
    endfunction

    // Expected output vectors per state, written straight from the state table.
    function automatic logic [21:0] ef(input logic rdy);
        return pk(4'd0, 1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b010);
    endfunction
    function automatic logic [21:0] ef_err();
        return pk(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b010);
    endfunction
    function automatic logic [21:0] ed(input logic ill);
        return pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill, 2'b00, 2'b11, 3'b010);
    endfunction
    function automatic logic [21:0] ema();
        return pk(4'd2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
    endfunction
    function automatic logic [21:0] emr(input logic merr);
        return pk(4'd3, 1, 0, 1, 0, 0, 0, 0, 0, 0, merr, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [21:0] emwb();
        return pk(4'd4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [21:0] emw(input logic merr);
        return pk(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 0, merr, 0, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic logic [21:0] eex(input logic [2:0] aop, input logic ill);
        return pk(4'd6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ill, 2'b00, 2'b00, aop);
    endfunction
    function automatic logic [21:0] erwb(input logic [2:0] aop);
        return pk(4'd7, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, aop);
    endfunction
    function automatic logic [21:0] ebr(input logic z);
        return pk(4'd8, 0, 0, 0, 0, z, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b110);
    endfunction
    function automatic logic [21:0] ej();
        return pk(4'd9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000);
    endfunction

    task automatic check_out();
        logic [21:0] act, e;
        string       t;
        act = {State, MemRead, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst,
               RegWrite, MemtoReg, MemErr, Illegal, PCSource, ALUSrcB, ALUop};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, act, e);
        end
    endtask

    task automatic chk1(input string t, input logic obs, input logic e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic drive(input string t, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy, input logic [21:0] e);
        OpCode   = op;
        func     = fn;
        Zero     = z;
        MemReady = rdy;
        exp_q.push_back(e);
        tag_q.push_back(t);
        #2;
        check_out();
    endtask

    task automatic step(input string t, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [21:0] e);
        drive(t, op, fn, z, rdy, e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string t);
        chk1({t, "_state0"}, State == 4'd0, 1'b1);
        chk1({t, "_memread"}, MemRead, 1'b0);
        chk1({t, "_memwrite"}, MemWrite, 1'b0);
        chk1({t, "_irwrite"}, IRWrite, 1'b0);
        chk1({t, "_pcen"}, PCEn, 1'b0);
        chk1({t, "_regwrite"}, RegWrite, 1'b0);
        chk1({t, "_memerr"}, MemErr, 1'b0);
        chk1({t, "_illegal"}, Illegal, 1'b0);
    endtask

    logic [5:0] r_fn  [4];
    logic [2:0] r_aop [4];

    initial begin
        r_fn[0] = F_ADD; r_aop[0] = 3'b010;
        r_fn[1] = F_SUB; r_aop[1] = 3'b110;
        r_fn[2] = F_AND; r_aop[2] = 3'b000;
        r_fn[3] = F_OR;  r_aop[3] = 3'b001;

        #3;
        chk_reset("rst_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step("r_fetch", OP_R, r_fn[i], 0, 1, ef(1));
            step("r_decode", OP_R, r_fn[i], 0, 1, ed(0));
            step("r_exec", OP_R, r_fn[i], 0, 1, eex(r_aop[i], 0));
            step("r_rwb", OP_R, r_fn[i], 0, 1, erwb(r_aop[i]));
        end

        step("lw_fetch", OP_LW, 6'd0, 0, 1, ef(1));
        step("lw_decode", OP_LW, 6'd0, 0, 1, ed(0));
        step("lw_memadr", OP_LW, 6'd0, 0, 1, ema());
        step("lw_memrd_w0", OP_LW, 6'd0, 0, 0, emr(0));
        step("lw_memrd_w1", OP_LW, 6'd0, 0, 0, emr(0));
        step("lw_memrd_done", OP_LW, 6'd0, 0, 1, emr(0));
        step("lw_memwb", OP_LW, 6'd0, 0, 1, emwb());

        step("beq1_fetch", OP_BEQ, 6'd0, 1, 1, ef(1));
        step("beq1_decode", OP_BEQ, 6'd0, 1, 1, ed(0));
        step("beq1_branch", OP_BEQ, 6'd0, 1, 1, ebr(1));
        step("beq0_fetch", OP_BEQ, 6'd0, 0, 1, ef(1));
        step("beq0_decode", OP_BEQ, 6'd0, 0, 1, ed(0));
        step("beq0_branch", OP_BEQ, 6'd0, 0, 1, ebr(0));

        step("badop_fetch", OP_BAD, 6'd0, 0, 1, ef(1));
        step("badop_decode", OP_BAD, 6'd0, 0, 1, ed(1));
        step("badfn_fetch", OP_R, F_BAD, 0, 1, ef(1));
        step("badfn_decode", OP_R, F_BAD, 0, 1, ed(0));
        step("badfn_exec", OP_R, F_BAD, 0, 1, eex(3'b010, 1));

        step("swto_fetch", OP_SW, 6'd0, 0, 1, ef(1));
        step("swto_decode", OP_SW, 6'd0, 0, 1, ed(0));
        step("swto_memadr", OP_SW, 6'd0, 0, 1, ema());
        step("swto_memwr0", OP_SW, 6'd0, 0, 0, emw(0));
        step("swto_memwr1", OP_SW, 6'd0, 0, 0, emw(0));
        step("swto_memwr2", OP_SW, 6'd0, 0, 0, emw(0));
        step("swto_memwr3_err", OP_SW, 6'd0, 0, 0, emw(1));

        step("swlate_fetch", OP_SW, 6'd0, 0, 1, ef(1));
        step("swlate_decode", OP_SW, 6'd0, 0, 1, ed(0));
        step("swlate_memadr", OP_SW, 6'd0, 0, 1, ema());
        step("swlate_memwr0", OP_SW, 6'd0, 0, 0, emw(0));
        step("swlate_memwr1", OP_SW, 6'd0, 0, 0, emw(0));
        step("swlate_memwr2", OP_SW, 6'd0, 0, 0, emw(0));
        step("swlate_memwr3_ok", OP_SW, 6'd0, 0, 1, emw(0));

        step("fto_w0", OP_J, 6'd0, 0, 0, ef(0));
        step("fto_w1", OP_J, 6'd0, 0, 0, ef(0));
        step("fto_w2", OP_J, 6'd0, 0, 0, ef(0));
        step("fto_err", OP_J, 6'd0, 0, 0, ef_err());
        step("fto_cleared", OP_J, 6'd0, 0, 0, ef(0));
        step("j_fetch", OP_J, 6'd0, 0, 1, ef(1));
        step("j_decode", OP_J, 6'd0, 0, 1, ed(0));
        step("j_jump", OP_J, 6'd0, 0, 1, ej());

        step("swrst_fetch", OP_SW, 6'd0, 0, 1, ef(1));
        step("swrst_decode", OP_SW, 6'd0, 0, 1, ed(0));
        step("swrst_memadr", OP_SW, 6'd0, 0, 1, ema());
        step("swrst_memwr0", OP_SW, 6'd0, 0, 0, emw(0));
        drive("swrst_memwr1", OP_SW, 6'd0, 0, 0, emw(0));
        MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        rst_n = 1'b1;
        step("post_rst_fetch", OP_J, 6'd0, 0, 1, ef(1));
        step("post_rst_decode", OP_J, 6'd0, 0, 1, ed(0));
        step("post_rst_jump", OP_J, 6'd0, 0, 1, ej());
        step("post_rst_refetch", OP_R, F_ADD, 0, 1, ef(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
